// File: rtl/uctl_line_event_ctrl.sv
// uctl_line_event_ctrl: always-on USB line-event controller.
// Times qualified J-idle, SE0 and K periods from the glitch-filtered line to
// flag suspend, bus reset and resume. It also selects the filter stable time
// per power mode and re-arms the filters after each mode change.
module uctl_line_event_ctrl #(
    parameter int unsigned                GLITCH_CNTR_WD = 4,
    parameter int unsigned                CNT_WD         = 16,
    parameter logic [CNT_WD-1:0]          SUSPEND_TIME   = 16'd3000,
    parameter logic [CNT_WD-1:0]          RESET_TIME     = 16'd250,
    parameter logic [CNT_WD-1:0]          RESUME_TIME    = 16'd200,
    parameter logic [GLITCH_CNTR_WD-1:0]  ACT_FILT       = 4'd3,
    parameter logic [GLITCH_CNTR_WD-1:0]  SUSP_FILT      = 4'd15
) (
    input  logic                       aon_clk,
    input  logic                       aon_rst_n,
    input  logic                       sw_rst,
    input  logic                       ctrl_en,
    input  logic [1:0]                 line_state,
    input  logic                       line_stable,
    output logic [GLITCH_CNTR_WD-1:0]  filt_stable_time,
    output logic                       filt_rearm,
    output logic                       suspend_o,
    output logic                       bus_reset_pulse,
    output logic                       resume_pulse
);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_IDLE_J,
        ST_SE0_CNT,
        ST_RST_HOLD,
        ST_SUSPEND,
        ST_RESUME_K
    } state_t;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    // Last counted value before each event fires; the entry edge supplies the
    // extra cycle so events land on the (TIME+1)th qualified cycle.
    localparam logic [CNT_WD-1:0] SUSP_LAST = SUSPEND_TIME - CNT_WD'(1);
    localparam logic [CNT_WD-1:0] RST_LAST  = RESET_TIME   - CNT_WD'(1);
    localparam logic [CNT_WD-1:0] RES_LAST  = RESUME_TIME  - CNT_WD'(1);

    state_t                      state;
    logic [CNT_WD-1:0]           tmr;
    logic [GLITCH_CNTR_WD-1:0]   filt_prev;
    logic                        q_j;
    logic                        q_k;
    logic                        q_se0;

    assign q_j   = line_stable && (line_state == LS_J);
    assign q_k   = line_stable && (line_state == LS_K);
    assign q_se0 = line_stable && (line_state == LS_SE0);

    // Line-event FSM with event timer and registered mode/event outputs.
    always_ff @(posedge aon_clk or negedge aon_rst_n) begin
        if (!aon_rst_n) begin
            state            <= ST_ACTIVE;
            tmr              <= '0;
            suspend_o        <= 1'b0;
            bus_reset_pulse  <= 1'b0;
            resume_pulse     <= 1'b0;
            filt_stable_time <= ACT_FILT;
        end else if (sw_rst) begin
            state            <= ST_ACTIVE;
            tmr              <= '0;
            suspend_o        <= 1'b0;
            bus_reset_pulse  <= 1'b0;
            resume_pulse     <= 1'b0;
            filt_stable_time <= ACT_FILT;
        end else begin
            bus_reset_pulse <= 1'b0;
            resume_pulse    <= 1'b0;
            if (!ctrl_en) begin
                state            <= ST_ACTIVE;
                tmr              <= '0;
                suspend_o        <= 1'b0;
                filt_stable_time <= ACT_FILT;
            end else begin
                case (state)
                    ST_ACTIVE: begin
                        tmr <= '0;
                        if (q_j)        state <= ST_IDLE_J;
                        else if (q_se0) state <= ST_SE0_CNT;
                    end
                    ST_IDLE_J: begin
                        if (q_j) begin
                            if (tmr == SUSP_LAST) begin
                                state            <= ST_SUSPEND;
                                tmr              <= '0;
                                suspend_o        <= 1'b1;
                                filt_stable_time <= SUSP_FILT;
                            end else begin
                                tmr <= tmr + CNT_WD'(1);
                            end
                        end else if (q_se0) begin
                            state <= ST_SE0_CNT;
                            tmr   <= '0;
                        end else begin
                            state <= ST_ACTIVE;
                            tmr   <= '0;
                        end
                    end
                    ST_SE0_CNT: begin
                        if (q_se0) begin
                            if (tmr == RST_LAST) begin
                                state            <= ST_RST_HOLD;
                                tmr              <= '0;
                                bus_reset_pulse  <= 1'b1;
                                suspend_o        <= 1'b0;
                                filt_stable_time <= ACT_FILT;
                            end else begin
                                tmr <= tmr + CNT_WD'(1);
                            end
                        end else begin
                            // Short SE0 is an EOP; a short SE0 seen from suspend
                            // still counts as bus activity and wakes the block.
                            state            <= ST_ACTIVE;
                            tmr              <= '0;
                            suspend_o        <= 1'b0;
                            filt_stable_time <= ACT_FILT;
                        end
                    end
                    ST_RST_HOLD: begin
                        tmr <= '0;
                        if (!q_se0) state <= ST_ACTIVE;
                    end
                    ST_SUSPEND: begin
                        tmr <= '0;
                        if (q_k)        state <= ST_RESUME_K;
                        else if (q_se0) state <= ST_SE0_CNT;
                    end
                    ST_RESUME_K: begin
                        if (q_k) begin
                            if (tmr == RES_LAST) begin
                                state            <= ST_ACTIVE;
                                tmr              <= '0;
                                resume_pulse     <= 1'b1;
                                suspend_o        <= 1'b0;
                                filt_stable_time <= ACT_FILT;
                            end else begin
                                tmr <= tmr + CNT_WD'(1);
                            end
                        end else begin
                            state <= ST_SUSPEND;
                            tmr   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_ACTIVE;
                        tmr   <= '0;
                    end
                endcase
            end
        end
    end

    // Pulse filt_rearm on the edge after the filter stable time changes.
    always_ff @(posedge aon_clk or negedge aon_rst_n) begin
        if (!aon_rst_n) begin
            filt_prev  <= ACT_FILT;
            filt_rearm <= 1'b0;
        end else if (sw_rst) begin
            filt_prev  <= ACT_FILT;
            filt_rearm <= 1'b0;
        end else begin
            filt_prev  <= filt_stable_time;
            filt_rearm <= (filt_stable_time != filt_prev);
        end
    end

endmodule

// File: tb/tb_uctl_line_event_ctrl.sv
// tb_uctl_line_event_ctrl: directed scenarios plus randomized line segments
// checked against a run-length model of the line-event rules.
module tb_uctl_line_event_ctrl;

    localparam int ST = 20;
    localparam int RT = 10;
    localparam int RS = 5;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       aon_clk = 1'b0;
    logic       aon_rst_n;
    logic       sw_rst;
    logic       ctrl_en;
    logic [1:0] line_state;
    logic       line_stable;
    logic [3:0] filt_stable_time;
    logic       filt_rearm;
    logic       suspend_o;
    logic       bus_reset_pulse;
    logic       resume_pulse;
    logic [7:0] obs;

    int n_chk  = 0;
    int n_fail = 0;

    uctl_line_event_ctrl #(
        .GLITCH_CNTR_WD (4),
        .CNT_WD         (16),
        .SUSPEND_TIME   (16'd20),
        .RESET_TIME     (16'd10),
        .RESUME_TIME    (16'd5),
        .ACT_FILT       (4'd3),
        .SUSP_FILT      (4'd15)
    ) dut (
        .aon_clk          (aon_clk),
        .aon_rst_n        (aon_rst_n),
        .sw_rst           (sw_rst),
        .ctrl_en          (ctrl_en),
        .line_state       (line_state),
        .line_stable      (line_stable),
        .filt_stable_time (filt_stable_time),
        .filt_rearm       (filt_rearm),
        .suspend_o        (suspend_o),
        .bus_reset_pulse  (bus_reset_pulse),
        .resume_pulse     (resume_pulse)
    );

    always #5 aon_clk = ~aon_clk;

    assign obs = {suspend_o, bus_reset_pulse, resume_pulse, filt_rearm, filt_stable_time};

    // Expected {suspend, bus_reset, resume, rearm, stable_time} from the mode rules.
    function automatic logic [7:0] exp_vec(input logic s, input logic br,
                                           input logic rs, input logic rr);
        return {s, br, rs, rr, (s ? 4'd15 : 4'd3)};
    endfunction

    task automatic cyc(input logic st, input logic [1:0] ls, input int n);
        repeat (n) begin
            line_stable = st;
            line_state  = ls;
            @(posedge aon_clk);
            #1;
        end
    endtask

    task automatic do_sw_rst();
        sw_rst = 1'b1;
        cyc(1'b1, SE1, 1);
        sw_rst = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_por: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        cyc(1'b1, J, 10);
        aon_rst_n = 1'b0;
        #2;
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_async_midcount: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        @(posedge aon_clk);
        #1;
        aon_rst_n = 1'b1;
        cyc(1'b1, J, ST + 1);
        n_chk++;
        if (obs !== exp_vec(1, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_then_suspend: got %b expected %b", obs, exp_vec(1, 0, 0, 0));
        end
        // sw_rst lands on the edge that would carry the rearm pulse
        sw_rst = 1'b1;
        cyc(1'b1, J, 1);
        sw_rst = 1'b0;
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_sw_over_pulse: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_sw_after: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_suspend();
        do_sw_rst();
        for (int i = 1; i <= ST + 1; i++) begin
            cyc(1'b1, J, 1);
            n_chk++;
            if (obs !== exp_vec(i == ST + 1, 0, 0, 0)) begin
                n_fail++; $display("FAIL suspend_j_cycle%0d: got %b expected %b", i, obs, exp_vec(i == ST + 1, 0, 0, 0));
            end
        end
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(1, 0, 0, 1)) begin
            n_fail++; $display("FAIL suspend_rearm: got %b expected %b", obs, exp_vec(1, 0, 0, 1));
        end
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(1, 0, 0, 0)) begin
            n_fail++; $display("FAIL suspend_rearm_end: got %b expected %b", obs, exp_vec(1, 0, 0, 0));
        end
        do_sw_rst();
        cyc(1'b1, J, ST);
        cyc(1'b1, K, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL suspend_j20_k: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        cyc(1'b1, J, ST);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL suspend_j20_after_k: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_bus_reset();
        int pulses;
        do_sw_rst();
        for (int i = 1; i <= RT + 1; i++) begin
            cyc(1'b1, SE0, 1);
            n_chk++;
            if (obs !== exp_vec(0, i == RT + 1, 0, 0)) begin
                n_fail++; $display("FAIL busrst_se0_cycle%0d: got %b expected %b", i, obs, exp_vec(0, i == RT + 1, 0, 0));
            end
        end
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL busrst_release: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        cyc(1'b1, SE1, 1);
        pulses = 0;
        for (int i = 0; i < RT - 1; i++) begin
            cyc(1'b1, SE0, 1);
            pulses += int'(bus_reset_pulse);
        end
        cyc(1'b1, SE1, 1);
        pulses += int'(bus_reset_pulse);
        n_chk++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL busrst_short_se0: pulses=%0d expected 0", pulses);
        end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, SE0, 1);
            pulses += int'(bus_reset_pulse);
        end
        cyc(1'b1, SE1, 1);
        pulses += int'(bus_reset_pulse);
        n_chk++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL busrst_long_se0: pulses=%0d expected 1", pulses);
        end
    endtask

    task automatic test_resume();
        do_sw_rst();
        cyc(1'b1, J, ST + 2);
        for (int i = 1; i <= RS + 1; i++) begin
            cyc(1'b1, K, 1);
            n_chk++;
            if (obs !== exp_vec(i <= RS, 0, i == RS + 1, 0)) begin
                n_fail++; $display("FAIL resume_k_cycle%0d: got %b expected %b", i, obs, exp_vec(i <= RS, 0, i == RS + 1, 0));
            end
        end
        cyc(1'b1, K, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL resume_rearm: got %b expected %b", obs, exp_vec(0, 0, 0, 1));
        end
        do_sw_rst();
        cyc(1'b1, J, ST + 3);
        cyc(1'b1, K, RS - 1);
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(1, 0, 0, 0)) begin
            n_fail++; $display("FAIL resume_k4_j: got %b expected %b", obs, exp_vec(1, 0, 0, 0));
        end
        cyc(1'b1, K, RS);
        n_chk++;
        if (obs !== exp_vec(1, 0, 0, 0)) begin
            n_fail++; $display("FAIL resume_k5: got %b expected %b", obs, exp_vec(1, 0, 0, 0));
        end
        cyc(1'b1, K, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 1, 0)) begin
            n_fail++; $display("FAIL resume_k6: got %b expected %b", obs, exp_vec(0, 0, 1, 0));
        end
    endtask

    task automatic test_reset_from_suspend();
        do_sw_rst();
        cyc(1'b1, J, ST + 3);
        for (int i = 1; i <= RT + 1; i++) begin
            cyc(1'b1, SE0, 1);
            n_chk++;
            if (obs !== exp_vec(i <= RT, i == RT + 1, 0, 0)) begin
                n_fail++; $display("FAIL suspbr_se0_cycle%0d: got %b expected %b", i, obs, exp_vec(i <= RT, i == RT + 1, 0, 0));
            end
        end
        cyc(1'b1, SE0, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL suspbr_rearm: got %b expected %b", obs, exp_vec(0, 0, 0, 1));
        end
    endtask

    task automatic test_restart();
        for (int v = 0; v < 2; v++) begin
            do_sw_rst();
            cyc(1'b1, J, 16);
            if (v == 0) cyc(1'b0, J, 1);
            else        do_sw_rst();
            cyc(1'b1, J, ST);
            n_chk++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                n_fail++; $display("FAIL restart%0d_j20: got %b expected %b", v, obs, exp_vec(0, 0, 0, 0));
            end
            cyc(1'b1, J, 1);
            n_chk++;
            if (obs !== exp_vec(1, 0, 0, 0)) begin
                n_fail++; $display("FAIL restart%0d_j21: got %b expected %b", v, obs, exp_vec(1, 0, 0, 0));
            end
        end
    endtask

    task automatic test_disable();
        int seen;
        do_sw_rst();
        ctrl_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, J, 1);
            seen += int'(suspend_o) + int'(bus_reset_pulse) + int'(resume_pulse);
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, SE0, 1);
            seen += int'(suspend_o) + int'(bus_reset_pulse) + int'(resume_pulse);
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL disable_no_events: events=%0d expected 0", seen);
        end
        ctrl_en = 1'b1;
        cyc(1'b1, SE1, 1);
        cyc(1'b1, J, ST + 3);
        ctrl_en = 1'b0;
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL disable_from_suspend: got %b expected %b", obs, exp_vec(0, 0, 0, 0));
        end
        cyc(1'b1, J, 1);
        n_chk++;
        if (obs !== exp_vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL disable_rearm: got %b expected %b", obs, exp_vec(0, 0, 0, 1));
        end
        ctrl_en = 1'b1;
    endtask

    // Random segments: one SE1 separator, then one condition held for len cycles.
    // Model: asleep flag plus position within the run decides each event.
    task automatic test_random();
        logic       asleep, seg_asleep, p1, p2, br, rs, rr, st;
        logic [1:0] ls;
        int         cond, len;
        do_sw_rst();
        asleep = 1'b0; p1 = 1'b0; p2 = 1'b0;
        for (int s = 0; s < 60; s++) begin
            seg_asleep = asleep;
            cond = asleep ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
            len  = (asleep && cond == 2) ? int'($urandom_range(RT + 1, RT + 8))
                                         : int'($urandom_range(1, 26));
            for (int k = 0; k <= len; k++) begin
                st = 1'b1;
                ls = SE1;
                if (k > 0) begin
                    case (cond)
                        0: ls = J;
                        1: ls = K;
                        2: ls = SE0;
                        3: ls = SE1;
                        default: begin st = 1'b0; ls = 2'($urandom_range(0, 3)); end
                    endcase
                end
                br = (k > 0) && (cond == 2) && (k == RT + 1);
                rs = (k > 0) && (cond == 1) && seg_asleep && (k == RS + 1);
                if ((k > 0) && (cond == 0) && !seg_asleep && (k == ST + 1)) asleep = 1'b1;
                if (br || rs) asleep = 1'b0;
                rr = (p1 != p2);
                cyc(st, ls, 1);
                n_chk++;
                if (obs !== exp_vec(asleep, br, rs, rr)) begin
                    n_fail++; $display("FAIL random_seg%0d_cond%0d_k%0d: got %b expected %b", s, cond, k, obs, exp_vec(asleep, br, rs, rr));
                end
                p2 = p1;
                p1 = asleep;
            end
        end
    endtask

    initial begin
        aon_rst_n   = 1'b0;
        sw_rst      = 1'b0;
        ctrl_en     = 1'b1;
        line_state  = SE1;
        line_stable = 1'b1;
        repeat (3) @(posedge aon_clk);
        #1;
        aon_rst_n = 1'b1;
        test_reset();
        test_suspend();
        test_bus_reset();
        test_resume();
        test_reset_from_suspend();
        test_restart();
        test_disable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
